mem_port_arbiter: RTL and testbench

//  Shares the single unified memory port between instruction fetch (IF) and the MEM-stage data access.

---
 rtl/proc_mem_pkg.sv | 26 ++
 rtl/mem_timeout_ctr.sv | 49 ++++
 rtl/mem_port_arbiter.sv | 230 +++++++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 429 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/proc_mem_pkg.sv
// Shared types and constants for the unified memory port arbiter.
//   state_e      : arbiter FSM states
//   gnt_e        : which requester owns the current transaction
//   TIMEOUT_DATA : read data returned when memory never acknowledges
//   ADDR_W       : address / data width of the memory port
package proc_mem_pkg;

    localparam int unsigned ADDR_W       = 32;
    localparam logic [31:0] TIMEOUT_DATA = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_e;

    typedef enum logic {
        GNT_IF = 1'b0,
        GNT_D  = 1'b1
    } gnt_e;

    function automatic logic [31:0] sext_byte(input logic [7:0] b);
        return {{24{b[7]}}, b};
    endfunction

endpackage

// File: rtl/mem_timeout_ctr.sv
// Watchdog for one outstanding memory transaction.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   clear      : restart the count (asserted on every grant)
//   en         : counting window (arbiter is waiting on mem_ack)
//   ack        : memory acknowledged this cycle; suppresses expiry
//   expired    : comb flag, MEM_TIMEOUT-th waiting cycle passed without ack
module mem_timeout_ctr
    import proc_mem_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic en,
    input  logic ack,
    output logic expired
);

    localparam int unsigned   CW   = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [CW-1:0] LAST = CW'(MEM_TIMEOUT - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d   = cnt_q;
        expired = 1'b0;
        if (clear) begin
            cnt_d = '0;
        end else if (en && !ack) begin
            // An ack on the last cycle wins, so expiry is qualified by !ack.
            if (cnt_q == LAST) begin
                expired = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch (IF) and MEM-stage data
// access (D). One transaction at a time; D has priority over IF.
// Optional feature: define ARB_FETCH_FAIR_EN to let IF win after
// MAX_D_STREAK consecutive D grants made while IF was waiting.
// Ports:
//   clk, reset              : clock, synchronous active-high reset
//   if_req/if_addr          : fetch request (word read)
//   if_ready/if_rdata       : 1-cycle retire pulse and fetched word
//   d_req/d_we/d_word/d_addr/d_wdata : data request fields
//   d_ready/d_rdata         : 1-cycle retire pulse and load data (byte sign-extended)
//   mem_req/mem_we/mem_word/mem_addr/mem_wdata : memory request, held until ack
//   mem_rdata/mem_ack       : memory response
//   mem_err                 : sticky timeout flag
module mem_port_arbiter
    import proc_mem_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT  = 16,
    parameter int unsigned MAX_D_STREAK = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ready,
    output logic [31:0]       if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic              d_word,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [31:0]       d_wdata,
    output logic              d_ready,
    output logic [31:0]       d_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic              mem_word,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ack,
    output logic              mem_err
);

    state_e            state_q, state_d;
    gnt_e              gnt_q, gnt_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic              mem_word_q, mem_word_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic              if_ready_q, if_ready_d;
    logic              d_ready_q, d_ready_d;
    logic [31:0]       if_rdata_q, if_rdata_d;
    logic [31:0]       d_rdata_q, d_rdata_d;
    logic              mem_err_q, mem_err_d;

    logic              grant;
    logic              take_d;
    logic              done;
    logic              tmo_expired;
    logic [31:0]       resp_data;

    mem_timeout_ctr #(
        .MEM_TIMEOUT(MEM_TIMEOUT)
    ) u_timeout (
        .clk    (clk),
        .reset  (reset),
        .clear  (grant),
        .en     (state_q == BUSY),
        .ack    (mem_ack),
        .expired(tmo_expired)
    );

`ifdef ARB_FETCH_FAIR_EN
    localparam int unsigned SW = $clog2(MAX_D_STREAK + 1);

    logic [SW-1:0] streak_q, streak_d;

    // IF takes its turn once D has won MAX_D_STREAK times in a row against it.
    always_comb begin
        take_d = d_req && !(if_req && (streak_q == SW'(MAX_D_STREAK)));
    end

    always_comb begin
        streak_d = streak_q;
        if (!if_req) begin
            streak_d = '0;
        end else if (grant && (gnt_d == GNT_IF)) begin
            streak_d = '0;
        end else if (grant && (gnt_d == GNT_D)) begin
            streak_d = streak_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            streak_q <= '0;
        end else begin
            streak_q <= streak_d;
        end
    end
`else
    // Strict priority: the streak limit only matters when fairness is built in.
    logic unused_streak_cfg;

    always_comb begin
        take_d            = d_req;
        unused_streak_cfg = ^MAX_D_STREAK;
    end
`endif

    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_word_d  = mem_word_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_ready_d  = 1'b0;
        d_ready_d   = 1'b0;
        if_rdata_d  = if_rdata_q;
        d_rdata_d   = d_rdata_q;
        mem_err_d   = mem_err_q;
        grant       = 1'b0;
        done        = 1'b0;
        resp_data   = mem_rdata;

        unique case (state_q)
            IDLE: begin
                if (take_d) begin
                    grant       = 1'b1;
                    gnt_d       = GNT_D;
                    mem_req_d   = 1'b1;
                    mem_we_d    = d_we;
                    mem_word_d  = d_word;
                    mem_addr_d  = d_addr;
                    mem_wdata_d = d_word ? d_wdata : {24'b0, d_wdata[7:0]};
                    state_d     = BUSY;
                end else if (if_req) begin
                    grant       = 1'b1;
                    gnt_d       = GNT_IF;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b0;
                    mem_word_d  = 1'b1;
                    mem_addr_d  = if_addr;
                    mem_wdata_d = '0;
                    state_d     = BUSY;
                end
            end

            BUSY: begin
                if (mem_ack) begin
                    done      = 1'b1;
                    resp_data = mem_rdata;
                end else if (tmo_expired) begin
                    done      = 1'b1;
                    resp_data = TIMEOUT_DATA;
                    mem_err_d = 1'b1;
                end
                if (done) begin
                    state_d   = RESP;
                    mem_req_d = 1'b0;
                    if (gnt_q == GNT_D) begin
                        d_ready_d = 1'b1;
                        // The timeout marker is returned whole even for byte loads.
                        if (!mem_word_q && mem_ack) begin
                            d_rdata_d = sext_byte(mem_rdata[7:0]);
                        end else begin
                            d_rdata_d = resp_data;
                        end
                    end else begin
                        if_ready_d = 1'b1;
                        if_rdata_d = resp_data;
                    end
                end
            end

            RESP: begin
                state_d = IDLE;
            end

            default: begin
                state_d   = IDLE;
                mem_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            gnt_q       <= GNT_IF;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_word_q  <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_ready_q  <= 1'b0;
            d_ready_q   <= 1'b0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
            mem_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_word_q  <= mem_word_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_ready_q  <= if_ready_d;
            d_ready_q   <= d_ready_d;
            if_rdata_q  <= if_rdata_d;
            d_rdata_q   <= d_rdata_d;
            mem_err_q   <= mem_err_d;
        end
    end

    assign if_ready  = if_ready_q;
    assign if_rdata  = if_rdata_q;
    assign d_ready   = d_ready_q;
    assign d_rdata   = d_rdata_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_word  = mem_word_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_err   = mem_err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter. Inputs driven and outputs sampled on
// the falling clock edge. Fairness expectations follow ARB_FETCH_FAIR_EN.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic        if_ready;
    logic [31:0] if_rdata;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic        d_word = 1'b0;
    logic [31:0] d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic        d_ready;
    logic [31:0] d_rdata;
    logic        mem_req;
    logic        mem_we;
    logic        mem_word;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = '0;
    logic        mem_ack = 1'b0;
    logic        mem_err;

    int total = 0;
    int bad   = 0;

    mem_port_arbiter #(
        .MEM_TIMEOUT (16),
        .MAX_D_STREAK(4)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_ready (if_ready),
        .if_rdata (if_rdata),
        .d_req    (d_req),
        .d_we     (d_we),
        .d_word   (d_word),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_ready  (d_ready),
        .d_rdata  (d_rdata),
        .mem_req  (mem_req),
        .mem_we   (mem_we),
        .mem_word (mem_word),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .mem_ack  (mem_ack),
        .mem_err  (mem_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        total++;
        if ({if_ready, d_ready, if_rdata, d_rdata, mem_req, mem_we, mem_word,
             mem_addr, mem_wdata, mem_err} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: got req=%b addr=%h err=%b rdy=%b/%b want all 0",
                     mem_req, mem_addr, mem_err, if_ready, d_ready);
        end
        tick();
        total++;
        if (mem_req !== 1'b0) begin
            bad++;
            $display("FAIL reset_idle: got mem_req=%b want 0", mem_req);
        end
    endtask

    task automatic test_if_read();
        if_req  = 1'b1;
        if_addr = 32'h0000_0100;
        tick();
        total++;
        if ({mem_req, mem_we, mem_word, mem_addr} !== {1'b1, 1'b0, 1'b1, 32'h0000_0100}) begin
            bad++;
            $display("FAIL if_req_fields: got req=%b we=%b word=%b addr=%h want 1 0 1 00000100",
                     mem_req, mem_we, mem_word, mem_addr);
        end
        tick();
        tick();
        total++;
        if ({mem_req, if_ready} !== 2'b10) begin
            bad++;
            $display("FAIL if_wait: got req=%b ready=%b want 1 0", mem_req, if_ready);
        end
        mem_ack   = 1'b1;
        mem_rdata = 32'h1357_9BDF;
        tick();
        mem_ack = 1'b0;
        if_req  = 1'b0;
        total++;
        if ({if_ready, d_ready, mem_req, if_rdata} !== {3'b100, 32'h1357_9BDF}) begin
            bad++;
            $display("FAIL if_resp: got rdy=%b drdy=%b req=%b rdata=%h want 1 0 0 13579bdf",
                     if_ready, d_ready, mem_req, if_rdata);
        end
        tick();
        total++;
        if ({if_ready, if_rdata} !== {1'b0, 32'h1357_9BDF}) begin
            bad++;
            $display("FAIL if_hold: got rdy=%b rdata=%h want 0 13579bdf", if_ready, if_rdata);
        end
    endtask

    task automatic test_priority();
        if_req  = 1'b1;
        if_addr = 32'h0000_0200;
        d_req   = 1'b1;
        d_we    = 1'b0;
        d_word  = 1'b1;
        d_addr  = 32'h0000_0040;
        tick();
        total++;
        if ({mem_req, mem_we, mem_word, mem_addr} !== {3'b101, 32'h0000_0040}) begin
            bad++;
            $display("FAIL prio_d_first: got req=%b we=%b word=%b addr=%h want 1 0 1 00000040",
                     mem_req, mem_we, mem_word, mem_addr);
        end
        mem_ack   = 1'b1;
        mem_rdata = 32'hAAAA_5555;
        tick();
        mem_ack = 1'b0;
        d_req   = 1'b0;
        total++;
        if ({d_ready, if_ready, d_rdata} !== {2'b10, 32'hAAAA_5555}) begin
            bad++;
            $display("FAIL prio_d_resp: got drdy=%b irdy=%b rdata=%h want 1 0 aaaa5555",
                     d_ready, if_ready, d_rdata);
        end
        tick();
        total++;
        if (mem_req !== 1'b0) begin
            bad++;
            $display("FAIL prio_resp_no_sample: got mem_req=%b want 0", mem_req);
        end
        tick();
        total++;
        if ({mem_req, mem_addr} !== {1'b1, 32'h0000_0200}) begin
            bad++;
            $display("FAIL prio_if_second: got req=%b addr=%h want 1 00000200", mem_req, mem_addr);
        end
        mem_ack   = 1'b1;
        mem_rdata = 32'h0BAD_F00D;
        tick();
        mem_ack = 1'b0;
        if_req  = 1'b0;
        total++;
        if ({if_ready, if_rdata} !== {1'b1, 32'h0BAD_F00D}) begin
            bad++;
            $display("FAIL prio_if_resp: got rdy=%b rdata=%h want 1 0badf00d", if_ready, if_rdata);
        end
        tick();
    endtask

    task automatic test_byte_access();
        d_req  = 1'b1;
        d_we   = 1'b0;
        d_word = 1'b0;
        d_addr = 32'h0000_0041;
        tick();
        total++;
        if ({mem_req, mem_we, mem_word} !== 3'b100) begin
            bad++;
            $display("FAIL byte_load_fields: got req=%b we=%b word=%b want 1 0 0",
                     mem_req, mem_we, mem_word);
        end
        mem_ack   = 1'b1;
        mem_rdata = 32'h0000_0080;
        tick();
        mem_ack = 1'b0;
        d_req   = 1'b0;
        total++;
        if ({d_ready, d_rdata} !== {1'b1, 32'hFFFF_FF80}) begin
            bad++;
            $display("FAIL byte_load_neg: got rdy=%b rdata=%h want 1 ffffff80", d_ready, d_rdata);
        end
        tick();
        d_req  = 1'b1;
        d_addr = 32'h0000_0042;
        tick();
        mem_ack   = 1'b1;
        mem_rdata = 32'h1234_567F;
        tick();
        mem_ack = 1'b0;
        d_req   = 1'b0;
        total++;
        if ({d_ready, d_rdata} !== {1'b1, 32'h0000_007F}) begin
            bad++;
            $display("FAIL byte_load_pos: got rdy=%b rdata=%h want 1 0000007f", d_ready, d_rdata);
        end
        tick();
        d_req   = 1'b1;
        d_we    = 1'b1;
        d_word  = 1'b0;
        d_addr  = 32'h0000_0043;
        d_wdata = 32'h1234_56AB;
        tick();
        total++;
        if ({mem_req, mem_we, mem_word, mem_addr, mem_wdata} !==
            {3'b110, 32'h0000_0043, 32'h0000_00AB}) begin
            bad++;
            $display("FAIL byte_store_fields: got req=%b we=%b word=%b addr=%h wdata=%h want 1 1 0 00000043 000000ab",
                     mem_req, mem_we, mem_word, mem_addr, mem_wdata);
        end
        tick();
        total++;
        if (mem_wdata !== 32'h0000_00AB) begin
            bad++;
            $display("FAIL byte_store_stable: got wdata=%h want 000000ab", mem_wdata);
        end
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        d_req   = 1'b0;
        d_we    = 1'b0;
        total++;
        if ({d_ready, mem_req} !== 2'b10) begin
            bad++;
            $display("FAIL byte_store_resp: got rdy=%b req=%b want 1 0", d_ready, mem_req);
        end
        tick();
    endtask

    task automatic test_timeout();
        int cyc;
        if_req  = 1'b1;
        if_addr = 32'h0000_0300;
        cyc     = 0;
        do begin
            tick();
            cyc++;
        end while (!if_ready && cyc < 40);
        if_req = 1'b0;
        total++;
        if (cyc != 17) begin
            bad++;
            $display("FAIL timeout_latency: got ready after %0d cycles want 17", cyc);
        end
        total++;
        if ({if_ready, if_rdata, mem_err, mem_req} !== {1'b1, 32'hDEAD_BEEF, 2'b10}) begin
            bad++;
            $display("FAIL timeout_resp: got rdy=%b rdata=%h err=%b req=%b want 1 deadbeef 1 0",
                     if_ready, if_rdata, mem_err, mem_req);
        end
        tick();
        if_req  = 1'b1;
        if_addr = 32'h0000_0304;
        tick();
        mem_ack   = 1'b1;
        mem_rdata = 32'h0000_0001;
        tick();
        mem_ack = 1'b0;
        if_req  = 1'b0;
        total++;
        if ({if_ready, if_rdata, mem_err} !== {1'b1, 32'h0000_0001, 1'b1}) begin
            bad++;
            $display("FAIL timeout_err_sticky: got rdy=%b rdata=%h err=%b want 1 00000001 1",
                     if_ready, if_rdata, mem_err);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        total++;
        if (mem_err !== 1'b0) begin
            bad++;
            $display("FAIL timeout_err_clear: got err=%b want 0", mem_err);
        end
        d_req  = 1'b1;
        d_we   = 1'b0;
        d_word = 1'b1;
        d_addr = 32'h0000_0080;
        for (int i = 0; i < 16; i++) tick();
        total++;
        if ({d_ready, mem_req} !== 2'b01) begin
            bad++;
            $display("FAIL timeout_last_wait: got rdy=%b req=%b want 0 1", d_ready, mem_req);
        end
        mem_ack   = 1'b1;
        mem_rdata = 32'h600D_CAFE;
        tick();
        mem_ack = 1'b0;
        d_req   = 1'b0;
        total++;
        if ({d_ready, d_rdata, mem_err} !== {1'b1, 32'h600D_CAFE, 1'b0}) begin
            bad++;
            $display("FAIL timeout_ack_wins: got rdy=%b rdata=%h err=%b want 1 600dcafe 0",
                     d_ready, d_rdata, mem_err);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        d_req   = 1'b1;
        d_we    = 1'b1;
        d_word  = 1'b1;
        d_addr  = 32'h0000_0090;
        d_wdata = 32'h1122_3344;
        tick();
        total++;
        if ({mem_req, mem_wdata} !== {1'b1, 32'h1122_3344}) begin
            bad++;
            $display("FAIL rstmid_busy: got req=%b wdata=%h want 1 11223344", mem_req, mem_wdata);
        end
        reset = 1'b1;
        d_req = 1'b0;
        d_we  = 1'b0;
        tick();
        reset   = 1'b0;
        mem_ack = 1'b1;
        total++;
        if ({if_ready, d_ready, if_rdata, d_rdata, mem_req, mem_we, mem_word,
             mem_addr, mem_wdata, mem_err} !== '0) begin
            bad++;
            $display("FAIL rstmid_outputs: got req=%b drdy=%b addr=%h wdata=%h want all 0",
                     mem_req, d_ready, mem_addr, mem_wdata);
        end
        tick();
        mem_ack = 1'b0;
        total++;
        if ({d_ready, if_ready, mem_req} !== 3'b000) begin
            bad++;
            $display("FAIL rstmid_stray_ack: got drdy=%b irdy=%b req=%b want 0 0 0",
                     d_ready, if_ready, mem_req);
        end
        if_req  = 1'b1;
        if_addr = 32'h0000_0700;
        tick();
        total++;
        if ({mem_req, mem_addr} !== {1'b1, 32'h0000_0700}) begin
            bad++;
            $display("FAIL rstmid_idle_grant: got req=%b addr=%h want 1 00000700", mem_req, mem_addr);
        end
        mem_ack   = 1'b1;
        mem_rdata = 32'h7777_0000;
        tick();
        mem_ack = 1'b0;
        if_req  = 1'b0;
        total++;
        if ({if_ready, if_rdata} !== {1'b1, 32'h7777_0000}) begin
            bad++;
            $display("FAIL rstmid_if_resp: got rdy=%b rdata=%h want 1 77770000", if_ready, if_rdata);
        end
        tick();
    endtask

    task automatic test_fairness();
        int          wait_cyc;
        logic [31:0] exp_addr;
        int          n_grants;
`ifdef ARB_FETCH_FAIR_EN
        n_grants = 5;
`else
        n_grants = 6;
`endif
        d_req   = 1'b1;
        d_we    = 1'b0;
        d_word  = 1'b1;
        d_addr  = 32'h0000_0500;
        if_req  = 1'b1;
        if_addr = 32'h0000_0600;
        for (int g = 0; g < n_grants; g++) begin
`ifdef ARB_FETCH_FAIR_EN
            exp_addr = (g == 4) ? 32'h0000_0600 : 32'h0000_0500;
`else
            exp_addr = 32'h0000_0500;
`endif
            wait_cyc = 0;
            do begin
                tick();
                wait_cyc++;
            end while (!mem_req && wait_cyc < 10);
            total++;
            if ({mem_req, mem_addr} !== {1'b1, exp_addr}) begin
                bad++;
                $display("FAIL fair_grant%0d: got req=%b addr=%h want 1 %h",
                         g, mem_req, mem_addr, exp_addr);
            end
            mem_ack   = 1'b1;
            mem_rdata = 32'hC0DE_0000 + 32'(g);
            tick();
            mem_ack = 1'b0;
            if (g == n_grants - 1) begin
                d_req  = 1'b0;
                if_req = 1'b0;
            end
        end
        tick();
        tick();
        total++;
        if (mem_req !== 1'b0) begin
            bad++;
            $display("FAIL fair_drain: got mem_req=%b want 0", mem_req);
        end
    endtask

    initial begin
        tick();
        test_reset();
        test_if_read();
        test_priority();
        test_byte_access();
        test_timeout();
        test_reset_mid();
        test_fairness();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
